// File: rtl/ram8_arb_pkg.sv
// Shared types and default sizes for the two-port ram8 arbiter.
package ram8_arb_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin grant logic; last_grant decides contention and
// only moves when a grant is actually issued.
module rr_arb2
    import ram8_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    port_t last_grant;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (enable) begin
            if (a_req && b_req) begin
                if (last_grant == PORT_B) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_B;
        end else if (a_gnt) begin
            last_grant <= PORT_A;
        end else if (b_gnt) begin
            last_grant <= PORT_B;
        end
    end

endmodule

// File: rtl/ram8_arbiter.sv
// Shares one single-port ram8 between requesters A and B with registered
// read responses. Define RAM8_ARB_CLEAR_EN to zero the memory after reset.
module ram8_arbiter
    import ram8_arb_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [WIDTH-1:0]  a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [WIDTH-1:0]  a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [WIDTH-1:0]  b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [WIDTH-1:0]  b_rdata,
    output logic [WIDTH-1:0]  ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    input  logic [WIDTH-1:0]  ram_out,
    output logic              busy
);

    logic arb_en;

`ifdef RAM8_ARB_CLEAR_EN
    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // One zero write per cycle; leave CLEAR after the top address.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_next = clr_cnt + 1'b1;
            if (clr_cnt == {ADDR_W{1'b1}}) begin
                state_next = IDLE;
            end
        end
    end

    assign busy = (state == CLEAR);
`else
    assign busy = 1'b0;
`endif

    assign arb_en = !reset && !busy;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .enable (arb_en),
        .a_req  (a_req),
        .b_req  (b_req),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    always_comb begin
        ram_load = 1'b0;
        ram_addr = '0;
        ram_in   = '0;
        if (a_gnt) begin
            ram_load = a_we;
            ram_addr = a_addr;
            ram_in   = a_wdata;
        end else if (b_gnt) begin
            ram_load = b_we;
            ram_addr = b_addr;
            ram_in   = b_wdata;
        end
`ifdef RAM8_ARB_CLEAR_EN
        if (busy) begin
            ram_load = 1'b1;
            ram_addr = clr_cnt;
            ram_in   = '0;
        end
`endif
    end

    // Read data is captured at the grant edge; the idle port keeps its rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= ram_out;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram8_arbiter.sv
// Self-checking bench for ram8_arbiter with an attached ram8 memory model.
// Build with RAM8_ARB_CLEAR_EN defined to also cover the post-reset clear.
module tb_ram8_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        a_req = 1'b0;
    logic        a_we = 1'b0;
    logic [2:0]  a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic        a_gnt;
    logic        a_rvalid;
    logic [15:0] a_rdata;
    logic        b_req = 1'b0;
    logic        b_we = 1'b0;
    logic [2:0]  b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic        b_gnt;
    logic        b_rvalid;
    logic [15:0] b_rdata;
    logic [15:0] ram_in;
    logic [2:0]  ram_addr;
    logic        ram_load;
    logic [15:0] ram_out;
    logic        busy;

    logic [15:0] mem [8];

    int          checks = 0;
    int          errors = 0;

    bit          m_last_b;
    logic [15:0] m_mem [8];
    logic [15:0] exp_a_rdata;
    logic [15:0] exp_b_rdata;
    bit          last_ga;
    bit          last_gb;

    always #5 clk = ~clk;

    assign ram_out = mem[ram_addr];

    always @(posedge clk) begin
        if (ram_load) begin
            mem[ram_addr] <= ram_in;
        end
    end

    ram8_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_in   (ram_in),
        .ram_addr (ram_addr),
        .ram_load (ram_load),
        .ram_out  (ram_out),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One full cycle: drive at negedge, check the grant path, then the response.
    task automatic applyStimulus(input logic ar, input logic aw, input logic [2:0] aa,
                                 input logic [15:0] ad, input logic br, input logic bw,
                                 input logic [2:0] ba, input logic [15:0] bd);
        bit ga;
        bit gb;
        @(negedge clk);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (ar && br) begin
            if (m_last_b) ga = 1'b1;
            else gb = 1'b1;
        end else if (ar) begin
            ga = 1'b1;
        end else if (br) begin
            gb = 1'b1;
        end
        checkOutput("a_gnt", a_gnt, ga);
        checkOutput("b_gnt", b_gnt, gb);
        checkOutput("gnt_exclusive", a_gnt & b_gnt, 0);
        if (ga) begin
            checkOutput("ram_load_a", ram_load, aw);
            checkOutput("ram_addr_a", ram_addr, aa);
            if (aw) checkOutput("ram_in_a", ram_in, ad);
        end else if (gb) begin
            checkOutput("ram_load_b", ram_load, bw);
            checkOutput("ram_addr_b", ram_addr, ba);
            if (bw) checkOutput("ram_in_b", ram_in, bd);
        end else begin
            checkOutput("ram_load_idle", ram_load, 0);
            checkOutput("ram_addr_idle", ram_addr, 0);
            checkOutput("ram_in_idle", ram_in, 0);
        end
        @(posedge clk);
        if (ga && !aw) exp_a_rdata = m_mem[aa];
        if (gb && !bw) exp_b_rdata = m_mem[ba];
        if (ga && aw) m_mem[aa] = ad;
        if (gb && bw) m_mem[ba] = bd;
        if (ga) m_last_b = 1'b0;
        if (gb) m_last_b = 1'b1;
        last_ga = ga;
        last_gb = gb;
        #1;
        checkOutput("a_rvalid", a_rvalid, ga && !aw);
        checkOutput("b_rvalid", b_rvalid, gb && !bw);
        checkOutput("a_rdata", a_rdata, exp_a_rdata);
        checkOutput("b_rdata", b_rdata, exp_b_rdata);
    endtask

    // Asserts reset asynchronously wherever it is called and releases it after two edges.
    task automatic resetDut();
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0;
        #1;
        checkOutput("rst_a_rvalid", a_rvalid, 0);
        checkOutput("rst_b_rvalid", b_rvalid, 0);
        checkOutput("rst_a_rdata", a_rdata, 0);
        checkOutput("rst_b_rdata", b_rdata, 0);
        checkOutput("rst_a_gnt", a_gnt, 0);
        checkOutput("rst_b_gnt", b_gnt, 0);
        m_last_b = 1'b1;
        exp_a_rdata = '0;
        exp_b_rdata = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
`ifdef RAM8_ARB_CLEAR_EN
        b_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput("clr_busy", busy, 1);
            checkOutput("clr_a_gnt", a_gnt, 0);
            checkOutput("clr_ram_load", ram_load, 1);
            checkOutput("clr_ram_addr", ram_addr, i);
            checkOutput("clr_ram_in", ram_in, 0);
        end
        @(negedge clk);
        #1;
        checkOutput("clr_done_busy", busy, 0);
        checkOutput("clr_done_a_gnt", a_gnt, 1);
        a_req = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
`else
        a_req = 1'b0;
        b_req = 1'b0;
        #1;
        checkOutput("idle_busy", busy, 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic        pa_req, pa_we, pb_req, pb_we;
        logic [2:0]  pa_addr, pb_addr;
        logic [15:0] pa_wdata, pb_wdata;

        #1;
        resetDut();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 3'(i), 16'($urandom), 1'b0, 1'b0, 3'd0, 16'd0);
        end

        $display("[TB] single requester write then read");
        applyStimulus(1'b1, 1'b1, 3'd1, 16'hFFFF, 1'b0, 1'b0, 3'd0, 16'd0);
        applyStimulus(1'b1, 1'b0, 3'd1, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
        checkOutput("tp1_a_rdata", a_rdata, 16'hFFFF);

        $display("[TB] contention after reset");
        resetDut();
        applyStimulus(1'b1, 1'b1, 3'd2, 16'h00FF, 1'b0, 1'b0, 3'd0, 16'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 1'b1, 3'd3, 16'hFF00);
        applyStimulus(1'b1, 1'b0, 3'd2, 16'd0, 1'b1, 1'b0, 3'd3, 16'd0);
        checkOutput("tp2_a_first", a_rdata, 16'h00FF);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 3'd3, 16'd0);
        checkOutput("tp2_b_second", b_rdata, 16'hFF00);

        $display("[TB] sustained contention");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd6, 16'd0, 1'b1, 1'b0, 3'd7, 16'd0);
            checkOutput("tp3_alternate", last_ga, (i % 2) == 0);
        end

        $display("[TB] write then cross-port read");
        applyStimulus(1'b1, 1'b1, 3'd4, 16'h0F0F, 1'b0, 1'b0, 3'd0, 16'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 3'd4, 16'd0);
        checkOutput("tp4_b_rdata", b_rdata, 16'h0F0F);

        $display("[TB] reset behaviour and clear");
        applyStimulus(1'b1, 1'b1, 3'd5, 16'hF0F0, 1'b0, 1'b0, 3'd0, 16'd0);
        resetDut();
        applyStimulus(1'b1, 1'b0, 3'd5, 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
`ifdef RAM8_ARB_CLEAR_EN
        checkOutput("tp5_cleared", a_rdata, 16'h0000);
`else
        checkOutput("tp5_kept", a_rdata, 16'hF0F0);
`endif

        $display("[TB] reset during read response");
        applyStimulus(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 3'd5, 16'd0);
        resetDut();
        applyStimulus(1'b1, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 3'd1, 16'd0);
        checkOutput("tp6_a_first", last_ga, 1);

        $display("[TB] randomized traffic");
        pa_req = 1'b0; pa_we = 1'b0; pa_addr = '0; pa_wdata = '0;
        pb_req = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_wdata = '0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(pa_req, pa_we, pa_addr, pa_wdata, pb_req, pb_we, pb_addr, pb_wdata);
            if (last_ga || !pa_req) begin
                pa_req   = ($urandom_range(0, 3) != 0);
                pa_we    = 1'($urandom_range(0, 1));
                pa_addr  = 3'($urandom_range(0, 7));
                pa_wdata = 16'($urandom);
            end
            if (last_gb || !pb_req) begin
                pb_req   = ($urandom_range(0, 3) != 0);
                pb_we    = 1'($urandom_range(0, 1));
                pb_addr  = 3'($urandom_range(0, 7));
                pb_wdata = 16'($urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
